// File: rtl/hwpe_ctrl_uloop_gen.sv
// Parametrised microcode loop sequencer: nested loop counters plus per-level add microcode.
// Define HWPE_CTRL_ULOOP_OVF_EN to build the sticky carry-out flag on ovf_o.

module hwpe_ctrl_uloop_gen #(
    parameter int unsigned NB_LOOPS  = 6,
    parameter int unsigned LENGTH    = 16,
    parameter int unsigned NB_REG    = 4,
    parameter int unsigned NB_RO_REG = 28,
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 12,
    localparam int unsigned AW = (NB_REG > 1) ? $clog2(NB_REG) : 1,
    localparam int unsigned BW = (NB_RO_REG > 1) ? $clog2(NB_RO_REG) : 1,
    localparam int unsigned LW = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1,
    localparam int unsigned PW = (LENGTH > 1) ? $clog2(LENGTH) : 1,
    localparam int unsigned CW = 1 + AW + BW
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              enable_i,
    input  logic [LW-1:0]                     accum_loop_i,
    input  logic [NB_LOOPS*PW-1:0]            loops_addr_i,
    input  logic [NB_LOOPS*(PW+1)-1:0]        loops_nbops_i,
    input  logic [LENGTH*CW-1:0]              code_i,
    input  logic [NB_LOOPS*CNT_WIDTH-1:0]     range_i,
    input  logic [NB_RO_REG*REG_WIDTH-1:0]    ro_reg_i,
    output logic                              valid_o,
    output logic                              done_o,
    output logic                              busy_o,
    output logic                              accum_o,
    output logic [NB_REG*REG_WIDTH-1:0]       offs_o,
    output logic [NB_LOOPS*CNT_WIDTH-1:0]     idx_o,
    output logic                              ovf_o
);

    typedef enum logic [1:0] {IDLE, UPDATE, ISSUE, TERMINATE} state_t;

    state_t               state_d, state_q;
    logic                 started_d, started_q;
    logic [PW-1:0]        ptr_d, ptr_q;
    logic [PW:0]          cnt_d, cnt_q;
    logic [REG_WIDTH-1:0] regs_d [NB_REG];
    logic [REG_WIDTH-1:0] regs_q [NB_REG];
    logic [CNT_WIDTH-1:0] idx_d [NB_LOOPS];
    logic [CNT_WIDTH-1:0] idx_q [NB_LOOPS];
    logic                 valid_d, valid_q, done_d, done_q, busy_d, busy_q;

    logic [PW-1:0]        addr_w  [NB_LOOPS];
    logic [PW:0]          nbops_w [NB_LOOPS];
    logic [CNT_WIDTH-1:0] last_w  [NB_LOOPS];
    logic [CW-1:0]        code_w  [LENGTH];
    logic [REG_WIDTH-1:0] ro_w    [NB_RO_REG];

    for (genvar g = 0; g < NB_LOOPS; g++) begin : g_level
        logic [CNT_WIDTH-1:0] rng;
        assign rng        = range_i[g*CNT_WIDTH +: CNT_WIDTH];
        // A range of 0 behaves like 1: the level never advances.
        assign last_w[g]  = (rng == '0) ? '0 : rng - 1'b1;
        assign addr_w[g]  = loops_addr_i[g*PW +: PW];
        assign nbops_w[g] = loops_nbops_i[g*(PW+1) +: PW+1];
        assign idx_o[g*CNT_WIDTH +: CNT_WIDTH] = idx_q[g];
    end

    for (genvar g = 0; g < LENGTH; g++) begin : g_word
        assign code_w[g] = code_i[g*CW +: CW];
    end

    for (genvar g = 0; g < NB_RO_REG; g++) begin : g_ro
        assign ro_w[g] = ro_reg_i[g*REG_WIDTH +: REG_WIDTH];
    end

    for (genvar g = 0; g < NB_REG; g++) begin : g_offs
        assign offs_o[g*REG_WIDTH +: REG_WIDTH] = regs_q[g];
    end

    logic                 op_sel;
    logic [AW-1:0]        op_a, op_rb;
    logic [BW-1:0]        op_b;
    logic [REG_WIDTH-1:0] op_lhs, op_rhs;

    always_comb begin
        op_sel = code_w[ptr_q][CW-1];
        op_a   = code_w[ptr_q][BW +: AW];
        op_b   = code_w[ptr_q][BW-1:0];
        op_rb  = AW'(32'(op_b) % NB_REG);
        op_lhs = regs_q[op_a];
        op_rhs = regs_q[op_rb];
        if (op_sel) begin
            op_rhs = (32'(op_b) < NB_RO_REG) ? ro_w[op_b] : '0;
        end
    end

`ifdef HWPE_CTRL_ULOOP_OVF_EN
    logic [REG_WIDTH:0]   sum;
    logic                 ovf_d, ovf_q;
    assign sum   = {1'b0, op_lhs} + {1'b0, op_rhs};
    assign ovf_o = ovf_q;
`else
    logic [REG_WIDTH-1:0] sum;
    assign sum   = op_lhs + op_rhs;
    assign ovf_o = 1'b0;
`endif

    logic          lvl_found;
    logic [LW-1:0] lvl;

    always_comb begin
        lvl_found = 1'b0;
        lvl       = '0;
        for (int unsigned i = 0; i < NB_LOOPS; i++) begin
            if (!lvl_found && idx_q[i] < last_w[i]) begin
                lvl_found = 1'b1;
                lvl       = LW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        regs_d    = regs_q;
        idx_d     = idx_q;
`ifdef HWPE_CTRL_ULOOP_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    if (!started_q) begin
                        started_d = 1'b1;
                        state_d   = ISSUE;
                    end else if (lvl_found) begin
                        idx_d[lvl] = idx_q[lvl] + 1'b1;
                        for (int unsigned j = 0; j < NB_LOOPS; j++) begin
                            if (j < 32'(lvl)) idx_d[j] = '0;
                        end
                        ptr_d   = addr_w[lvl];
                        cnt_d   = nbops_w[lvl];
                        state_d = UPDATE;
                    end else begin
                        state_d = TERMINATE;
                    end
                end
            end
            UPDATE: begin
                // cnt_q==0 on entry gives a single idle UPDATE cycle.
                if (cnt_q != '0) begin
                    regs_d[op_a] = sum[REG_WIDTH-1:0];
                    ptr_d        = (ptr_q == PW'(LENGTH-1)) ? '0 : ptr_q + 1'b1;
                    cnt_d        = cnt_q - 1'b1;
`ifdef HWPE_CTRL_ULOOP_OVF_EN
                    if (sum[REG_WIDTH]) ovf_d = 1'b1;
`endif
                end
                if (cnt_q <= 1) state_d = ISSUE;
            end
            ISSUE:     state_d = IDLE;
            TERMINATE: state_d = TERMINATE;
            default:   state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d   = IDLE;
            started_d = 1'b0;
            ptr_d     = '0;
            cnt_d     = '0;
            for (int unsigned r = 0; r < NB_REG; r++) regs_d[r] = '0;
            for (int unsigned l = 0; l < NB_LOOPS; l++) idx_d[l] = '0;
`ifdef HWPE_CTRL_ULOOP_OVF_EN
            ovf_d     = 1'b0;
`endif
        end
        valid_d = (state_d == ISSUE);
        done_d  = (state_d == TERMINATE);
        busy_d  = (state_d == UPDATE) || (state_d == ISSUE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            for (int unsigned r = 0; r < NB_REG; r++) regs_q[r] <= '0;
            for (int unsigned l = 0; l < NB_LOOPS; l++) idx_q[l] <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef HWPE_CTRL_ULOOP_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            regs_q    <= regs_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef HWPE_CTRL_ULOOP_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    always_comb begin
        accum_o = valid_q;
        for (int unsigned j = 0; j < NB_LOOPS; j++) begin
            if (j < 32'(accum_loop_i) && idx_q[j] != '0) accum_o = 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign busy_o  = busy_q;

endmodule
